// File: rtl/pipe_writeback.sv
// pipe_writeback: Y86-64 PIPE writeback stage (M/W register, register file, status/halt, retire counter); define PIPE_WB_BYPASS_EN for write-through reads
module pipe_writeback #(
  parameter int NREG  = 15,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       m_stat,
  input  logic [3:0]       m_icode,
  input  logic [63:0]      m_valE,
  input  logic [63:0]      m_valM,
  input  logic [3:0]       m_dstE,
  input  logic [3:0]       m_dstM,
  input  logic             W_stall,
  input  logic             W_bubble,
  input  logic [3:0]       srcA,
  input  logic [3:0]       srcB,
  output logic [63:0]      d_rvalA,
  output logic [63:0]      d_rvalB,
  output logic [2:0]       W_stat,
  output logic [3:0]       W_icode,
  output logic [63:0]      W_valE,
  output logic [63:0]      W_valM,
  output logic [3:0]       W_dstE,
  output logic [3:0]       W_dstM,
  output logic [2:0]       stat,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);
  localparam logic [2:0] BUB = 3'd0, AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
  localparam logic [3:0] RNONE = 4'hF, NOP = 4'h1;
  logic [2:0]       stat_q, stat_d, code_q, code_d;
  logic [3:0]       icode_q, icode_d, dste_q, dste_d, dstm_q, dstm_d;
  logic [63:0]      vale_q, vale_d, valm_q, valm_d;
  logic             halted_q, halted_d, load, we;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [63:0]      regs_q [NREG];
  logic [63:0]      regs_d [NREG];

  assign load = !halted_q && !W_stall;
  assign we   = !halted_q && stat_q == AOK;

  // M/W next state: hold on halt or stall, bubble loads the idle values
  always_comb begin
    stat_d  = !load ? stat_q  : W_bubble ? BUB   : m_stat;
    icode_d = !load ? icode_q : W_bubble ? NOP   : m_icode;
    vale_d  = !load ? vale_q  : W_bubble ? '0    : m_valE;
    valm_d  = !load ? valm_q  : W_bubble ? '0    : m_valM;
    dste_d  = !load ? dste_q  : W_bubble ? RNONE : m_dstE;
    dstm_d  = !load ? dstm_q  : W_bubble ? RNONE : m_dstM;
  end

  // M/W pipeline register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_q  <= BUB;
      icode_q <= NOP;
      vale_q  <= '0;
      valm_q  <= '0;
      dste_q  <= RNONE;
      dstm_q  <= RNONE;
    end else begin
      stat_q  <= stat_d;
      icode_q <= icode_d;
      vale_q  <= vale_d;
      valm_q  <= valm_d;
      dste_q  <= dste_d;
      dstm_q  <= dstm_d;
    end
  end

  // Register file next state; valM is applied last so it wins a shared destination
  always_comb begin
    regs_d = regs_q;
    if (we && dste_q != RNONE) regs_d[dste_q] = vale_q;
    if (we && dstm_q != RNONE) regs_d[dstm_q] = valm_q;
  end

  // Register file storage
  always_ff @(posedge clk) begin
    if (!rst_n) for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    else regs_q <= regs_d;
  end

  // Halt detection and retire counting, both frozen once halted
  always_comb begin
    halted_d  = halted_q || stat_q == HLT || stat_q == ADR || stat_q == INS;
    code_d    = halted_q ? code_q : stat_q;
    retired_d = retired_q + CNT_W'(we);
  end

  // Status and counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halted_q  <= 1'b0;
      code_q    <= AOK;
      retired_q <= '0;
    end else begin
      halted_q  <= halted_d;
      code_q    <= code_d;
      retired_q <= retired_d;
    end
  end

`ifdef PIPE_WB_BYPASS_EN
  assign d_rvalA = srcA == RNONE ? '0 : we && dstm_q == srcA ? valm_q : we && dste_q == srcA ? vale_q : regs_q[srcA];
  assign d_rvalB = srcB == RNONE ? '0 : we && dstm_q == srcB ? valm_q : we && dste_q == srcB ? vale_q : regs_q[srcB];
`else
  assign d_rvalA = srcA == RNONE ? '0 : regs_q[srcA];
  assign d_rvalB = srcB == RNONE ? '0 : regs_q[srcB];
`endif

  assign W_stat  = stat_q;
  assign W_icode = icode_q;
  assign W_valE  = vale_q;
  assign W_valM  = valm_q;
  assign W_dstE  = dste_q;
  assign W_dstM  = dstm_q;
  assign stat    = halted_q ? code_q : (stat_q == AOK || stat_q == BUB) ? AOK : stat_q;
  assign halted  = halted_q;
  assign retired = retired_q;
endmodule

// File: tb/tb_pipe_writeback.sv
// tb_pipe_writeback: directed checks of the PIPE writeback stage
module tb_pipe_writeback;
`ifdef PIPE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [2:0] m_stat;
  logic [3:0] m_icode, m_dstE, m_dstM, srcA, srcB;
  logic [63:0] m_valE, m_valM;
  logic W_stall = 1'b0, W_bubble = 1'b0;
  logic [63:0] d_rvalA, d_rvalB, W_valE, W_valM, x_rvalA, x_rvalB, x_valE, x_valM;
  logic [2:0] W_stat, stat, x_stat, x_sstat;
  logic [3:0] W_icode, W_dstE, W_dstM, x_icode, x_dstE, x_dstM;
  logic halted, x_halted;
  logic [31:0] retired;
  logic [2:0] x_retired;
  int checks = 0, errors = 0;

  pipe_writeback dut (.clk(clk), .rst_n(rst_n), .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE),
    .m_valM(m_valM), .m_dstE(m_dstE), .m_dstM(m_dstM), .W_stall(W_stall), .W_bubble(W_bubble),
    .srcA(srcA), .srcB(srcB), .d_rvalA(d_rvalA), .d_rvalB(d_rvalB), .W_stat(W_stat), .W_icode(W_icode),
    .W_valE(W_valE), .W_valM(W_valM), .W_dstE(W_dstE), .W_dstM(W_dstM), .stat(stat), .halted(halted),
    .retired(retired));

  pipe_writeback #(.CNT_W(3)) u_wrap (.clk(clk), .rst_n(rst_n), .m_stat(m_stat), .m_icode(m_icode),
    .m_valE(m_valE), .m_valM(m_valM), .m_dstE(m_dstE), .m_dstM(m_dstM), .W_stall(W_stall),
    .W_bubble(W_bubble), .srcA(srcA), .srcB(srcB), .d_rvalA(x_rvalA), .d_rvalB(x_rvalB),
    .W_stat(x_stat), .W_icode(x_icode), .W_valE(x_valE), .W_valM(x_valM), .W_dstE(x_dstE),
    .W_dstM(x_dstM), .stat(x_sstat), .halted(x_halted), .retired(x_retired));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] st, input logic [3:0] de, input logic [3:0] dm,
                       input logic [63:0] ve, input logic [63:0] vm);
    m_stat = st; m_icode = 4'h6; m_dstE = de; m_dstM = dm; m_valE = ve; m_valM = vm;
  endtask

  task automatic idle;
    drive(3'd0, 4'hF, 4'hF, 64'h0, 64'h0);
    m_icode = 4'h1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; idle(); tick(); tick(); rst_n = 1'b1;
  endtask

  task automatic test_reset;
    drive(3'd1, 4'h0, 4'h0, 64'hAA, 64'hBB);
    rst_n = 1'b0; tick(); tick();
    srcA = 4'h0; srcB = 4'hF; #1;
    checks++; if (W_stat !== 3'd0) begin errors++; $display("FAIL rst_W_stat got %0d want 0", W_stat); end
    checks++; if (W_icode !== 4'h1) begin errors++; $display("FAIL rst_W_icode got %h want 1", W_icode); end
    checks++; if (W_valE !== 64'h0 || W_valM !== 64'h0) begin errors++; $display("FAIL rst_W_val got %h/%h want 0/0", W_valE, W_valM); end
    checks++; if (W_dstE !== 4'hF || W_dstM !== 4'hF) begin errors++; $display("FAIL rst_W_dst got %h/%h want F/F", W_dstE, W_dstM); end
    checks++; if (stat !== 3'd1 || halted !== 1'b0) begin errors++; $display("FAIL rst_stat got %0d/%b want 1/0", stat, halted); end
    checks++; if (retired !== 32'd0) begin errors++; $display("FAIL rst_retired got %0d want 0", retired); end
    checks++; if (d_rvalA !== 64'h0 || d_rvalB !== 64'h0) begin errors++; $display("FAIL rst_rval got %h/%h want 0/0", d_rvalA, d_rvalB); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_write;
    drive(3'd1, 4'h0, 4'hF, 64'h5, 64'h0); srcA = 4'h0;
    tick();
    checks++; if (W_valE !== 64'h5 || W_dstE !== 4'h0) begin errors++; $display("FAIL basic_W got %h/%h want 5/0", W_valE, W_dstE); end
    checks++; if (d_rvalA !== (BYP ? 64'h5 : 64'h0)) begin errors++; $display("FAIL basic_pre_commit got %h want %h", d_rvalA, BYP ? 64'h5 : 64'h0); end
    idle(); tick();
    checks++; if (d_rvalA !== 64'h5) begin errors++; $display("FAIL basic_commit got %h want 5", d_rvalA); end
    checks++; if (retired !== 32'd1) begin errors++; $display("FAIL basic_retired got %0d want 1", retired); end
  endtask

  task automatic test_popq;
    drive(3'd1, 4'h4, 4'h4, 64'h8, 64'h10); srcB = 4'h4;
    tick(); idle(); tick();
    checks++; if (d_rvalB !== 64'h10) begin errors++; $display("FAIL popq_valM_wins got %h want 10", d_rvalB); end
    checks++; if (retired !== 32'd2) begin errors++; $display("FAIL popq_retired got %0d want 2", retired); end
  endtask

  task automatic test_stall_bubble;
    drive(3'd1, 4'h5, 4'hF, 64'h55, 64'h0); srcA = 4'h5; srcB = 4'h6;
    tick();
    W_stall = 1'b1; drive(3'd1, 4'h6, 4'hF, 64'h66, 64'h0);
    for (int k = 0; k < 3; k++) begin
      W_bubble = (k == 2);
      tick();
      checks++; if (W_dstE !== 4'h5 || W_valE !== 64'h55) begin errors++; $display("FAIL stall_hold%0d got %h/%h want 5/55", k, W_dstE, W_valE); end
      checks++; if (d_rvalA !== 64'h55) begin errors++; $display("FAIL stall_r5_%0d got %h want 55", k, d_rvalA); end
    end
    W_stall = 1'b0; W_bubble = 1'b1;
    tick();
    W_bubble = 1'b0; idle();
    checks++; if (W_stat !== 3'd0 || W_dstE !== 4'hF) begin errors++; $display("FAIL bubble_W got %0d/%h want 0/F", W_stat, W_dstE); end
    tick();
    checks++; if (d_rvalB !== 64'h0) begin errors++; $display("FAIL bubble_no_write got %h want 0", d_rvalB); end
    checks++; if (retired !== 32'd6) begin errors++; $display("FAIL stall_retired got %0d want 6", retired); end
  endtask

  task automatic test_bypass;
    drive(3'd1, 4'h3, 4'hF, 64'h7, 64'h0);
    tick();
    srcB = 4'h3; idle(); #1;
    checks++; if (d_rvalB !== (BYP ? 64'h7 : 64'h0)) begin errors++; $display("FAIL bypass_same_cycle got %h want %h", d_rvalB, BYP ? 64'h7 : 64'h0); end
    tick();
    checks++; if (d_rvalB !== 64'h7) begin errors++; $display("FAIL bypass_after_edge got %h want 7", d_rvalB); end
    checks++; if (retired !== 32'd7) begin errors++; $display("FAIL bypass_retired got %0d want 7", retired); end
  endtask

  task automatic test_halt;
    drive(3'd2, 4'h2, 4'hF, 64'h22, 64'h0); srcA = 4'h2;
    tick();
    checks++; if (stat !== 3'd2 || halted !== 1'b0) begin errors++; $display("FAIL halt_pre got %0d/%b want 2/0", stat, halted); end
    drive(3'd1, 4'h2, 4'hF, 64'h99, 64'h0);
    tick();
    checks++; if (halted !== 1'b1 || stat !== 3'd2) begin errors++; $display("FAIL halt_set got %b/%0d want 1/2", halted, stat); end
    checks++; if (d_rvalA !== 64'h0) begin errors++; $display("FAIL halt_no_write got %h want 0", d_rvalA); end
    drive(3'd1, 4'h3, 4'hF, 64'h33, 64'h0);
    tick(); tick();
    checks++; if (W_valE !== 64'h99 || W_dstE !== 4'h2) begin errors++; $display("FAIL halt_W_hold got %h/%h want 99/2", W_valE, W_dstE); end
    checks++; if (d_rvalA !== 64'h0 || halted !== 1'b1 || stat !== 3'd2) begin errors++; $display("FAIL halt_sticky got %h/%b/%0d want 0/1/2", d_rvalA, halted, stat); end
    checks++; if (retired !== 32'd7) begin errors++; $display("FAIL halt_retired_frozen got %0d want 7", retired); end
    srcB = 4'h4; do_reset(); #1;
    checks++; if (halted !== 1'b0 || stat !== 3'd1 || retired !== 32'd0) begin errors++; $display("FAIL halt_reset got %b/%0d/%0d want 0/1/0", halted, stat, retired); end
    checks++; if (d_rvalB !== 64'h0 || W_stat !== 3'd0) begin errors++; $display("FAIL halt_reset_regs got %h/%0d want 0/0", d_rvalB, W_stat); end
  endtask

  task automatic test_adr;
    drive(3'd3, 4'hF, 4'h1, 64'h0, 64'h11); srcA = 4'h1;
    tick(); idle();
    checks++; if (stat !== 3'd3 || halted !== 1'b0) begin errors++; $display("FAIL adr_pre got %0d/%b want 3/0", stat, halted); end
    tick();
    checks++; if (stat !== 3'd3 || halted !== 1'b1 || d_rvalA !== 64'h0) begin errors++; $display("FAIL adr_halt got %0d/%b/%h want 3/1/0", stat, halted, d_rvalA); end
    do_reset();
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      drive(3'd1, 4'(i), 4'hF, 64'(i * 16 + 1), 64'h0);
      tick();
    end
    checks++; if (retired !== 32'd7 || x_retired !== 3'd7) begin errors++; $display("FAIL b2b_pre_wrap got %0d/%0d want 7/7", retired, x_retired); end
    idle(); tick();
    checks++; if (retired !== 32'd8) begin errors++; $display("FAIL b2b_retired got %0d want 8", retired); end
    checks++; if (x_retired !== 3'd0) begin errors++; $display("FAIL wrap_retired got %0d want 0", x_retired); end
    for (int i = 0; i < 8; i++) begin
      srcA = 4'(i); #1;
      checks++; if (d_rvalA !== 64'(i * 16 + 1)) begin errors++; $display("FAIL b2b_r%0d got %h want %h", i, d_rvalA, 64'(i * 16 + 1)); end
    end
  endtask

  initial begin
    idle(); srcA = 4'h0; srcB = 4'hF;
    test_reset();
    test_basic_write();
    test_popq();
    test_stall_bubble();
    test_bypass();
    test_halt();
    test_adr();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
